// File: rtl/gpr_bank_select.sv
// General-purpose register bank R0..R15 with IR field decode, sign-extended constant
// and lowest-index-wins bus source encoder feeding the 32:1 bus multiplexer.
module gpr_bank_select #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ir,
  input  logic                   gra,
  input  logic                   grb,
  input  logic                   grc,
  input  logic                   rin,
  input  logic                   rout,
  input  logic                   baout,
  input  logic [WIDTH-1:0]       bus_in,
  input  logic [7:0]             other_out,
  output logic [NREGS*WIDTH-1:0] r_flat,
  output logic [WIDTH-1:0]       c_sign_ext,
  output logic [4:0]             bus_sel,
  output logic                   multi_drive_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             err_q;
  logic             err_d;
  logic [3:0]       idx;
  logic [NREGS-1:0] dec;
  logic [30:0]      req;
  logic             unused_ir;

  assign unused_ir = ^ir[31:27];

  // Simultaneous field selects OR together rather than erroring.
  assign idx = ({4{gra}} & ir[26:23]) | ({4{grb}} & ir[22:19]) | ({4{grc}} & ir[18:15]);
  assign dec = (gra | grb | grc) ? (NREGS'(1) << idx) : '0;

  assign req = {7'b0, other_out, dec & {NREGS{rout | baout}}};

  assign c_sign_ext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  always_comb begin
    bus_sel = 5'd31;
    for (int i = 30; i >= 0; i--) begin
      if (req[i]) bus_sel = 5'(i);
    end
  end

  always_comb begin
    r_flat = '0;
    for (int k = 0; k < NREGS; k++) begin
      r_flat[k*WIDTH +: WIDTH] = regs_q[k];
    end
    if (baout) r_flat[WIDTH-1:0] = '0;
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign err_d = err_q | ((req & (req - 31'd1)) != 31'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      err_q <= err_d;
      if (rin) begin
        for (int k = 0; k < NREGS; k++) begin
          if (dec[k]) regs_q[k] <= bus_in;
        end
      end
    end
  end

  assign multi_drive_err = err_q;

endmodule

// File: doc/gpr_bank_select.md
Name: gpr_bank_select

Overview:
- General-purpose register bank (R0–R15) plus IR-driven select/encode logic and bus-source encoder.
- Sits directly upstream of the 32:1 bus multiplexer. It supplies the register contents for mux inputs 0–15 and the 5-bit bus select.
- It also supplies the sign-extended constant C and captures bus writes into the selected GPR.

Parameters:
- WIDTH, 32, datapath/register width.
- NREGS, 16, number of GPRs. Fixed by the 4-bit IR register fields; not intended to change.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ir  in  32  current instruction register value.
- gra  in  1  select Ra field (IR[26:23]).
- grb  in  1  select Rb field (IR[22:19]).
- grc  in  1  select Rc field (IR[18:15]).
- rin  in  1  load bus into selected GPR.
- rout  in  1  drive selected GPR onto bus.
- baout  in  1  drive selected GPR onto bus, with R0 reading as zero.
- bus_in  in  WIDTH  bus value to be written.
- other_out  in  8  one-hot-ish drive requests for sources 16..23: HI, LO, ZHI, ZLO, PC, MDR, INPORT, COUT.
- r_flat  out  NREGS*WIDTH  register values for mux inputs 0..15; slice k = R(k).
- c_sign_ext  out  WIDTH  IR[18:0] sign-extended from bit 18 (mux input 23).
- bus_sel  out  5  mux select.
- multi_drive_err  out  1  sticky flag: more than one source requested in a cycle.

Behaviour:
- Register field decode:
  - idx = ({4{gra}} & IR[26:23]) | ({4{grb}} & IR[22:19]) | ({4{grc}} & IR[18:15]).
  - dec = one-hot(idx), and is all-zero when none of gra/grb/grc is asserted.
- Write:
  - On rising clk, if rin && dec[k], R(k) <= bus_in. Only one register is written per cycle.
  - R0 is writable.
- Read:
  - r_flat is driven combinationally from the flops.
  - Slice 0 is forced to 0 when baout=1; otherwise it is R0.
  - Other slices are always the register contents.
  - Read and write of the same register in the same cycle returns the old value; the new value is visible the next cycle.
- Source requests:
  - req[15:0] = dec & {16{rout|baout}}.
  - req[23:16] = other_out.
  - req[30:24] = 0.
- bus_sel (combinational):
  - Index of the lowest set bit of req.
  - If req is all-zero, bus_sel = 5'd31; the integrator ties mux input 31 to zero.
- c_sign_ext: {{13{IR[18]}}, IR[18:0]}, combinational.
- multi_drive_err:
  - Reset value 0.
  - Set at the clock edge when popcount(req) >= 2 in that cycle.
  - Stays 1 until reset.
  - The error does not alter bus_sel priority.
- Reset:
  - Synchronous. On rising clk with reset=1, all R(k) <= 0 and multi_drive_err <= 0.
  - Reset takes priority over a simultaneous rin write.
  - Combinational outputs follow the inputs during reset: bus_sel = 31 if idle, r_flat = 0 after the edge.
- Zero latency for all select paths; single-cycle write latency.
- gra/grb/grc combined simultaneously yields the bitwise OR of the fields. This is legal but unusual; no error is raised.

Test Plan:
- Reset then read:
  - Stimulus: assert reset for 1 cycle, then gra=1 with IR[26:23]=4'd5 and rout=1.
  - Required: r_flat slice 5 = 0, bus_sel = 5'd5, multi_drive_err = 0.
- Write/read:
  - Stimulus: IR[26:23]=3, gra=1, rin=1, bus_in=32'hDEADBEEF for 1 cycle; next cycle rin=0, rout=1.
  - Required: slice 3 = 32'hDEADBEEF, bus_sel = 3, other slices unchanged at 0.
- R0/baout:
  - Stimulus: write 32'h12345678 into R0 via grb (IR[22:19]=0); then grb=1, baout=1.
  - Required: slice 0 = 0 and bus_sel = 0.
  - Stimulus: switch to rout=1, baout=0.
  - Required: slice 0 = 32'h12345678.
- Constant:
  - Stimulus: IR[18:0]=19'h40001.
  - Required: c_sign_ext = 32'hFFFC0001.
  - Stimulus: IR[18:0]=19'h00005.
  - Required: c_sign_ext = 32'h00000005.
- Encoder/idle/conflict:
  - Stimulus: other_out=8'b0001_0000 (PC), no GPR request.
  - Required: bus_sel = 20.
  - Stimulus: all requests low.
  - Required: bus_sel = 31.
  - Stimulus: grc=1 with IR[18:15]=7, rout=1, and other_out[1]=1 (LO).
  - Required: bus_sel = 7, multi_drive_err = 1 after the edge, still 1 after requests clear, 0 after reset.
- Reset vs write:
  - Stimulus: rin=1, bus_in=32'hFFFFFFFF on R9 in the same cycle as reset=1.
  - Required: R9 = 0 afterwards.
